// File: rtl/mult_pkg.sv
// Shared definitions for the 16x9 shift-add multiplier.
// Holds the operand/counter widths and the control-word bit layout that both
// the control ROM and the datapath use, so the ROM word and the datapath
// control ports cannot drift apart. Also holds the datapath operation decode
// used by the top to steer the {A,Q} register.
package mult_pkg;

  localparam int WA = 16;       // multiplicand width
  localparam int WB = 9;        // multiplier width and iteration count
  localparam int CW = 4;        // iteration counter width, 2**CW must exceed WB
  localparam int PW = WA + WB;  // product width

  // Control-word bit positions as stored in the control ROM.
  localparam int CTRL_LD   = 3;
  localparam int CTRL_ADD  = 2;
  localparam int CTRL_SHR  = 1;
  localparam int CTRL_DONE = 0;
  localparam int CTRL_W    = 4;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  // Operation applied to the {A,Q} register on one edge.
  typedef enum logic [2:0] {
    ACC_HOLD,
    ACC_LOAD,
    ACC_ADD,
    ACC_SHR,
    ACC_ADD_SHR
  } acc_op_e;

  // LD dominates; ADD and SHR combine into the fused step when both are set.
  function automatic acc_op_e decode_acc_op(input logic ld, input logic add,
                                            input logic shr);
    if (ld)              return ACC_LOAD;
    else if (add && shr) return ACC_ADD_SHR;
    else if (add)        return ACC_ADD;
    else if (shr)        return ACC_SHR;
    else                 return ACC_HOLD;
  endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// Bus between the multiplier control logic and the datapath.
// master: control logic side -- drives operands and control lines
//         (MCAND, MPLIER, LD, ADD, SHR, DONE), receives the status flags
//         and product (Q0, CNTZ, PRODUCT, VALID).
// slave:  datapath side -- the mirror image.
interface mult_datapath_if;
  import mult_pkg::*;

  logic [WA-1:0] MCAND;
  logic [WB-1:0] MPLIER;
  logic          LD;
  logic          ADD;
  logic          SHR;
  logic          DONE;
  logic          Q0;
  logic          CNTZ;
  logic [PW-1:0] PRODUCT;
  logic          VALID;

  modport master (
    output MCAND, MPLIER, LD, ADD, SHR, DONE,
    input  Q0, CNTZ, PRODUCT, VALID
  );

  modport slave (
    input  MCAND, MPLIER, LD, ADD, SHR, DONE,
    output Q0, CNTZ, PRODUCT, VALID
  );

endinterface

// File: rtl/shift_acc_reg.sv
// Combined {A,Q} register of the shift-add multiplier.
// A[WA:0] is the accumulator (A[WA] is the carry), Q[WB-1:0] starts as the
// multiplier and fills with the low product bits as it shifts out.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset, clears A and Q
//   op      operation for this edge (hold/load/add/shift/fused add+shift)
//   m       registered multiplicand
//   mplier  multiplier operand, captured into Q on load
//   product {A[WA-1:0],Q}
module shift_acc_reg
  import mult_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  acc_op_e       op,
  input  logic [WA-1:0] m,
  input  logic [WB-1:0] mplier,
  output logic [PW-1:0] product
);

  logic [WA:0]   a;
  logic [WB-1:0] q;
  logic [WA:0]   sum;

  // Carry of the add lands in sum[WA]; the fused step shifts it straight
  // into A[WA-1], so the carry is never dropped and A[WA] returns to 0.
  // NOTE: always_comb with one unconditional assignment cannot infer a latch.
  always_comb sum = {1'b0, m} + {1'b0, a[WA-1:0]};

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a <= '0;
      q <= '0;
    end else begin
      unique case (op)
        ACC_LOAD: begin
          a <= '0;
          q <= mplier;
        end
        ACC_ADD:     a      <= sum;
        ACC_SHR:     {a, q} <= {1'b0, a,   q[WB-1:1]};
        ACC_ADD_SHR: {a, q} <= {1'b0, sum, q[WB-1:1]};
        default:     ;  // ACC_HOLD
      endcase
    end
  end

  assign product = {a[WA-1:0], q};

endmodule

// File: rtl/mult_datapath.sv
// Shift-add datapath of the 16x9 sequential multiplier.
// Executes the control word from the control ROM each rising CLK edge and
// reports the status flags the next-state logic branches on.
// The sequencer changes the control word on the falling edge, so controls
// are settled half a cycle before each datapath edge.
// Ports:
//   CLK  datapath clock, all registers update on posedge
//   RST  synchronous active-low reset, overrides every control input
//   bus  slave side of mult_datapath_if:
//        MCAND/MPLIER operands (sampled only on LD), LD/ADD/SHR/DONE controls,
//        Q0 (multiplier LSB), CNTZ (counter at zero), PRODUCT {A,Q}, VALID
// Priority per edge: LD > ADD/SHR > hold; DONE acts independently of ADD/SHR.
// The datapath does not block ADD/SHR after DONE; that is the controller's job.
module mult_datapath
  import mult_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  mult_datapath_if.slave   bus
);

  logic [WA-1:0] m;
  logic [CW-1:0] cnt;
  logic          valid;
  logic [PW-1:0] product;
  acc_op_e       op;

  always_comb op = decode_acc_op(bus.LD, bus.ADD, bus.SHR);

  shift_acc_reg u_acc (
    .clk     (CLK),
    .rst_n   (RST),
    .op      (op),
    .m       (m),
    .mplier  (bus.MPLIER),
    .product (product)
  );

  // Multiplicand, iteration counter and completion flag.
  // The counter saturates at zero so a stray extra shift never wraps it
  // back to a non-zero count.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      m     <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (bus.LD) begin
      m     <= bus.MCAND;
      cnt   <= CW'(WB);
      valid <= 1'b0;
    end else begin
      if (bus.SHR && (cnt != '0)) cnt <= cnt - CW'(1);
      if (bus.DONE)               valid <= 1'b1;
    end
  end

  assign bus.Q0      = product[0];
  assign bus.CNTZ    = (cnt == '0);
  assign bus.PRODUCT = product;
  assign bus.VALID   = valid;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath.
// Drives the control word on the falling edge (as the sequencer does) and
// samples outputs 1 time unit after the rising edge.
module tb_mult_datapath;
  import mult_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  mult_datapath_if bus ();

  mult_datapath dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WA-1:0] mcand;
    logic [WB-1:0] mplier;
    logic [PW-1:0] product;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ctrl_word_t cw(input logic ld, input logic add,
                                    input logic shr, input logic done);
    ctrl_word_t w;
    w            = '0;
    w[CTRL_LD]   = ld;
    w[CTRL_ADD]  = add;
    w[CTRL_SHR]  = shr;
    w[CTRL_DONE] = done;
    return w;
  endfunction

  // One datapath edge with the given control word and operands.
  task automatic drive(input ctrl_word_t w, input logic [WA-1:0] mc,
                       input logic [WB-1:0] mp);
    @(negedge CLK);
    bus.LD     = w[CTRL_LD];
    bus.ADD    = w[CTRL_ADD];
    bus.SHR    = w[CTRL_SHR];
    bus.DONE   = w[CTRL_DONE];
    bus.MCAND  = mc;
    bus.MPLIER = mp;
    @(posedge CLK);
    #1;
  endtask

  // Non-load edge: operands are scrambled to show they are ignored.
  task automatic step(input ctrl_word_t w);
    drive(w, WA'($urandom), WB'($urandom));
  endtask

  task automatic reset_for(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(negedge CLK);
      RST        = 1'b0;
      bus.LD     = 1'($urandom);
      bus.ADD    = 1'($urandom);
      bus.SHR    = 1'($urandom);
      bus.DONE   = 1'($urandom);
      bus.MCAND  = WA'($urandom);
      bus.MPLIER = WB'($urandom);
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    RST      = 1'b1;
    bus.LD   = 1'b0;
    bus.ADD  = 1'b0;
    bus.SHR  = 1'b0;
    bus.DONE = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " product"}, bus.PRODUCT, '0);
    check({tag, " valid"},   PW'(bus.VALID), '0);
    check({tag, " cntz"},    PW'(bus.CNTZ),  PW'(1));
    check({tag, " q0"},      PW'(bus.Q0),    '0);
  endtask

  // Value of {A,Q} after k multiply steps: the partial product of the k
  // multiplier bits consumed so far, aligned above the bits still waiting.
  function automatic logic [PW-1:0] partial(input logic [WA-1:0] mc,
                                            input logic [WB-1:0] mp,
                                            input int k);
    longint low;
    longint val;
    low = longint'(mp) % (longint'(1) << k);
    val = ((longint'(mc) * low) << (WB - k)) | (longint'(mp) >> k);
    return PW'(val);
  endfunction

  // Canonical microprogram: LD, WB fused steps (ADD when the current
  // multiplier bit is 1), then DONE.
  task automatic run_mult(input string tag, input logic [WA-1:0] mc,
                          input logic [WB-1:0] mp, input logic [PW-1:0] exp);
    drive(cw(1'b1, 1'b0, 1'b0, 1'b0), mc, mp);
    check({tag, " load product"}, bus.PRODUCT, PW'(mp));
    for (int k = 0; k < WB; k++) begin
      check($sformatf("%s q0 step%0d", tag, k), PW'(bus.Q0), PW'(mp[k]));
      check($sformatf("%s cntz step%0d", tag, k), PW'(bus.CNTZ), '0);
      step(cw(1'b0, mp[k], 1'b1, 1'b0));
      check($sformatf("%s partial step%0d", tag, k), bus.PRODUCT,
            partial(mc, mp, k + 1));
    end
    check({tag, " cntz end"},   PW'(bus.CNTZ),  PW'(1));
    check({tag, " valid pre"},  PW'(bus.VALID), '0);
    step(cw(1'b0, 1'b0, 1'b0, 1'b1));
    check({tag, " valid"},   PW'(bus.VALID), PW'(1));
    check({tag, " product"}, bus.PRODUCT, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WA-1:0] mc;
    logic [WB-1:0] mp;
    logic [PW-1:0] shifted;

    bus.LD = 1'b0; bus.ADD = 1'b0; bus.SHR = 1'b0; bus.DONE = 1'b0;
    bus.MCAND = '0; bus.MPLIER = '0;

    vecs[0] = '{16'h1234, 9'h005, 25'h0005B04};
    vecs[1] = '{16'hFFFF, 9'h1FF, 25'h1FEFE01};
    vecs[2] = '{16'hABCD, 9'h000, 25'h0000000};
    vecs[3] = '{16'h0001, 9'h1FF, 25'h00001FF};
    vecs[4] = '{16'hFFFF, 9'h001, 25'h000FFFF};
    vecs[5] = '{16'h8000, 9'h100, 25'h0800000};
    vecs[6] = '{16'h0000, 9'h1AB, 25'h0000000};

    // Reset with random controls active.
    reset_for(2);
    check_cleared("reset");

    // Directed vectors.
    for (int i = 0; i < 7; i++)
      run_mult($sformatf("vec%0d", i), vecs[i].mcand, vecs[i].mplier,
               vecs[i].product);

    // Random operands against plain multiplication.
    for (int i = 0; i < 20; i++) begin
      mc = WA'($urandom);
      mp = WB'($urandom);
      run_mult($sformatf("rand%0d", i), mc, mp,
               PW'(longint'(mc) * longint'(mp)));
    end

    // LD with every other control set: only the load happens.
    drive(cw(1'b1, 1'b0, 1'b0, 1'b0), 16'h00FF, 9'h155);
    step(cw(1'b0, 1'b0, 1'b0, 1'b1));
    check("done sets valid", PW'(bus.VALID), PW'(1));
    drive(cw(1'b1, 1'b1, 1'b1, 1'b1), 16'h00FF, 9'h155);
    check("ld_all valid",   PW'(bus.VALID), '0);
    check("ld_all product", bus.PRODUCT, 25'h0000155);
    check("ld_all cntz",    PW'(bus.CNTZ), '0);
    check("ld_all q0",      PW'(bus.Q0), PW'(1));

    // ADD alone changes A but not the count.
    step(cw(1'b0, 1'b1, 1'b0, 1'b0));
    check("add_only product", bus.PRODUCT, 25'h001FF55);
    check("add_only cntz",    PW'(bus.CNTZ), '0);

    // Plain shifts: counter reaches zero on the 9th and then saturates,
    // while the shift keeps moving {A,Q}.
    for (int k = 1; k <= 11; k++) begin
      step(cw(1'b0, 1'b0, 1'b1, 1'b0));
      shifted = 25'h001FF55 >> k;
      check($sformatf("shr%0d product", k), bus.PRODUCT, shifted);
      check($sformatf("shr%0d cntz", k), PW'(bus.CNTZ), PW'(k >= WB));
    end

    // Reset in the middle of a multiply, then a fresh multiply.
    drive(cw(1'b1, 1'b0, 1'b0, 1'b0), 16'hFFFF, 9'h1FF);
    for (int k = 0; k < 4; k++) step(cw(1'b0, 1'b1, 1'b1, 1'b0));
    check("mid partial", bus.PRODUCT, partial(16'hFFFF, 9'h1FF, 4));
    reset_for(1);
    check_cleared("mid reset");
    run_mult("after_reset", 16'h0002, 9'h003, 25'h0000006);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Shift-add datapath for the 16x9 sequential multiplier.
- Consumes the control word decoded from the control ROM, which is addressed by the present-state register (`sequencer` output).
- Returns status flags Q0 and CNTZ to the next-state control logic and presents the 25-bit product.
- Registers update on the rising edge of CLK. The sequencer updates on the falling edge, so control lines are stable half a cycle before each datapath edge.

Parameters:
- WA, 16: multiplicand width.
- WB, 9: multiplier width; also the iteration count.
- CW, 4: iteration counter width; must satisfy 2^CW > WB.

Ports:
- CLK  input  1  datapath clock; all registers update on posedge.
- RST  input  1  reset, synchronous, active-low.
- MCAND  input  WA  multiplicand operand.
- MPLIER  input  WB  multiplier operand.
- LD  input  1  load operands, clear accumulator, set counter to WB, clear VALID.
- ADD  input  1  accumulate: A <= {1'b0,A[WA-1:0]} + {1'b0,M}.
- SHR  input  1  shift {A,Q} right one place, decrement counter.
- DONE  input  1  latch product valid.
- Q0  output  1  Q[0]; tells control logic whether to ADD.
- CNTZ  output  1  counter == 0.
- PRODUCT  output  WA+WB  {A[WA-1:0],Q}.
- VALID  output  1  product complete.

Behaviour:
- Registers:
  - M[WA-1:0] holds the multiplicand.
  - A[WA:0] is the accumulator, with A[WA] as carry.
  - Q[WB-1:0] holds the multiplier and becomes the low product bits.
  - CNT[CW-1:0] is the iteration counter.
  - VALID is a 1-bit register.
- Reset, when RST=0 at a posedge: M=0, A=0, Q=0, CNT=0, VALID=0. Hence Q0=0, CNTZ=1, PRODUCT=0. Reset overrides every control input, including mid-multiply.
- Control priority per edge: LD > (ADD/SHR) > hold. DONE is independent of ADD/SHR.
- LD=1:
  - M<=MCAND, Q<=MPLIER, A<=0, CNT<=WB, VALID<=0.
  - ADD, SHR and DONE are ignored in that cycle.
- ADD=1, SHR=0: A <= M + A[WA-1:0], zero-extended to WA+1 bits. Q and CNT are held.
- SHR=1, ADD=0:
  - {A,Q} <= {1'b0,A,Q[WB-1:1]}; A[0] enters Q[WB-1].
  - CNT <= CNT-1.
- ADD=1 and SHR=1 together (fused step, one cycle):
  - sum S = M + A[WA-1:0] is computed first.
  - Then {A,Q} <= {1'b0,S,Q[WB-1:1]}.
  - CNT decrements.
- CNT boundary: SHR with CNT=0 saturates CNT at 0; the counter never wraps. The shift still occurs.
- DONE=1 (without LD): VALID<=1. VALID stays 1 until the next LD or reset.
- The datapath itself does not gate on VALID. Any post-DONE ADD/SHR modifies A/Q; preventing that is the control logic's job.
- Flags Q0, CNTZ and PRODUCT are combinational from registers, with no added latency. Q0 reflects the new Q[0] one edge after SHR.
- Latency for the canonical microprogram (LD, then WB x fused {ADD if Q0, SHR}, then DONE): WB+2 datapath edges from LD to VALID=1.
- Arithmetic: the result is an unsigned WA x WB product. A[WA] is always 0 after each shift, so PRODUCT never loses the carry.
- Operands are sampled only on LD. Changes to MCAND/MPLIER at other times have no effect.

Decomposition:
- Shared package `mult_pkg` holds:
  - width constants WA=16, WB=9, CW=4, PW=WA+WB;
  - the control-word bit positions (LD, ADD, SHR, DONE) used by both the control ROM and this block, so the ROM word and datapath ports cannot drift.
- One natural sub-module: `shift_acc_reg`, the combined {A,Q} register with add/shift/fused-step logic.
- The counter and VALID stay in the top.

Test Plan:
- Reset: hold RST=0 for 2 edges with random controls asserted -> PRODUCT=0, VALID=0, CNTZ=1, Q0=0.
- 0x1234 x 0x005 via canonical microprogram -> after 11 edges PRODUCT=0x0005B04, VALID=1. Bench checks Q0 sequence 1,0,1,0,0,0,0,0,0 and CNTZ=1 only after the 9th SHR.
- 0xFFFF x 0x1FF (every step adds, max carry) -> PRODUCT=0x1FEFE01, VALID=1. A[16] is 0 after every shift.
- 0xABCD x 0x000 -> PRODUCT=0x0000000. ADD is never issued because Q0=0 throughout; VALID=1.
- Boundary controls:
  - LD+ADD+SHR+DONE in the same cycle -> only the load occurs: CNT=9, VALID=0.
  - 10th SHR at CNT=0 -> CNT stays 0; the shift still happens.
  - ADD alone -> A changes, CNT unchanged.
- Reset mid-multiply: assert RST=0 after 4 iterations of 0xFFFF x 0x1FF -> next edge all registers 0, then a fresh LD of 0x0002 x 0x003 yields PRODUCT=0x0000006.
